l2_cache: RTL and testbench

Unified, block-granular, write-back L2 cache between `L1_cache` and the `memory` model. It serves L1 line fills (`l1_read`) and absorbs L1 dirty-line evictions (`l1_write`) as whole `BLOCK_SIZE`-byte blocks. Its storage is set-associative with true-LRU replacement. On a miss it writes back a dirty victim to memory and, for reads only, fetches the missing block from memory.

---
 rtl/l2_cache.sv | 214 +++++++++++++++++++++
 tb/tb_l2_cache.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache.sv
// rtl/l2_cache.sv - set-associative write-back L2 cache with true-LRU, block-granular L1/memory ports
module l2_cache #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int CACHE_SIZE = 1024,
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_WAYS   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-1:0]                 l1_addr,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l1_data_in,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l1_data_out,
  input  logic                                  l1_read,
  input  logic                                  l1_write,
  output logic                                  l1_ready,
  output logic                                  l1_hit,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_in,
  output logic                                  mem_read,
  output logic                                  mem_write,
  input  logic                                  mem_ready
);

  localparam int OFF  = $clog2(BLOCK_SIZE);
  localparam int SETS = CACHE_SIZE / (BLOCK_SIZE * NUM_WAYS);
  localparam int IDX  = $clog2(SETS);
  localparam int TAG  = ADDR_WIDTH - IDX - OFF;
  localparam int WAYW = $clog2(NUM_WAYS);

  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] blk_t;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_FILL, S_RESPOND} state_t;

  state_t          r_state;
  logic            r_valid [SETS][NUM_WAYS];
  logic            r_dirty [SETS][NUM_WAYS];
  logic [TAG-1:0]  r_tag   [SETS][NUM_WAYS];
  blk_t            r_data  [SETS][NUM_WAYS];
  logic [WAYW-1:0] r_age   [SETS][NUM_WAYS];

  logic [TAG-1:0]  r_req_tag;
  logic [IDX-1:0]  r_req_idx;
  logic            r_op_wr;
  blk_t            r_wdata;
  logic [WAYW-1:0] r_victim;

  blk_t            r_l1_data_out;
  logic            r_l1_ready;
  logic            r_l1_hit;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  blk_t            r_mem_data_out;
  logic            r_mem_read;
  logic            r_mem_write;

  logic            w_hit;
  logic [WAYW-1:0] w_hit_way;
  logic            w_found_inv;
  logic [WAYW-1:0] w_victim;
  logic            w_touch;
  logic [WAYW-1:0] w_touch_way;
  logic [WAYW-1:0] w_touch_age;
  logic [WAYW-1:0] w_age_next [NUM_WAYS];
  logic            w_unused_off;

  assign w_unused_off = ^l1_addr[OFF-1:0];

  assign l1_data_out  = r_l1_data_out;
  assign l1_ready     = r_l1_ready;
  assign l1_hit       = r_l1_hit;
  assign mem_addr     = r_mem_addr;
  assign mem_data_out = r_mem_data_out;
  assign mem_read     = r_mem_read;
  assign mem_write    = r_mem_write;

  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_found_inv = 1'b0;
    w_victim    = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[r_req_idx][w] && (r_tag[r_req_idx][w] == r_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAYW'(w);
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!r_valid[r_req_idx][w] && !w_found_inv) begin
        w_found_inv = 1'b1;
        w_victim    = WAYW'(w);
      end
    end
    if (!w_found_inv) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (r_age[r_req_idx][w] == WAYW'(NUM_WAYS - 1)) w_victim = WAYW'(w);
      end
    end
  end

  // Ages stay a permutation: the touched way becomes youngest, younger ones shift up by one.
  always_comb begin
    w_touch     = ((r_state == S_LOOKUP) && w_hit) ||
                  ((r_state == S_FILL) && (r_op_wr || mem_ready));
    w_touch_way = (r_state == S_LOOKUP) ? w_hit_way : r_victim;
    w_touch_age = r_age[r_req_idx][w_touch_way];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAYW'(w) == w_touch_way)
        w_age_next[w] = '0;
      else if (r_age[r_req_idx][w] < w_touch_age)
        w_age_next[w] = r_age[r_req_idx][w] + 1'b1;
      else
        w_age_next[w] = r_age[r_req_idx][w];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_req_tag      <= '0;
      r_req_idx      <= '0;
      r_op_wr        <= 1'b0;
      r_wdata        <= '0;
      r_victim       <= '0;
      r_l1_data_out  <= '0;
      r_l1_ready     <= 1'b0;
      r_l1_hit       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_data_out <= '0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_tag[s][w]   <= '0;
          r_data[s][w]  <= '0;
          r_age[s][w]   <= WAYW'(w);
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (l1_write || l1_read) begin
            r_req_tag <= l1_addr[ADDR_WIDTH-1:IDX+OFF];
            r_req_idx <= l1_addr[IDX+OFF-1:OFF];
            r_op_wr   <= l1_write;
            r_wdata   <= l1_data_in;
            r_state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            if (r_op_wr) begin
              r_data[r_req_idx][w_hit_way]  <= r_wdata;
              r_dirty[r_req_idx][w_hit_way] <= 1'b1;
            end else begin
              r_l1_data_out <= r_data[r_req_idx][w_hit_way];
            end
            r_l1_ready <= 1'b1;
            r_l1_hit   <= 1'b1;
            r_state    <= S_RESPOND;
          end else begin
            r_victim <= w_victim;
            if (r_valid[r_req_idx][w_victim] && r_dirty[r_req_idx][w_victim]) begin
              r_mem_write    <= 1'b1;
              r_mem_addr     <= {r_tag[r_req_idx][w_victim], r_req_idx, {OFF{1'b0}}};
              r_mem_data_out <= r_data[r_req_idx][w_victim];
              r_state        <= S_WRITEBACK;
            end else begin
              if (!r_op_wr) begin
                r_mem_read <= 1'b1;
                r_mem_addr <= {r_req_tag, r_req_idx, {OFF{1'b0}}};
              end
              r_state <= S_FILL;
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ready) begin
            r_mem_write <= 1'b0;
            if (!r_op_wr) begin
              r_mem_read <= 1'b1;
              r_mem_addr <= {r_req_tag, r_req_idx, {OFF{1'b0}}};
            end
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (r_op_wr || mem_ready) begin
            r_valid[r_req_idx][r_victim] <= 1'b1;
            r_dirty[r_req_idx][r_victim] <= r_op_wr;
            r_tag[r_req_idx][r_victim]   <= r_req_tag;
            r_data[r_req_idx][r_victim]  <= r_op_wr ? r_wdata : mem_data_in;
            if (!r_op_wr) r_l1_data_out <= mem_data_in;
            r_mem_read <= 1'b0;
            r_l1_ready <= 1'b1;
            r_l1_hit   <= 1'b0;
            r_state    <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          r_l1_ready <= 1'b0;
          r_l1_hit   <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_touch) begin
        for (int w = 0; w < NUM_WAYS; w++) r_age[r_req_idx][w] <= w_age_next[w];
      end
    end
  end

endmodule

// File: tb/tb_l2_cache.sv
// tb/tb_l2_cache.sv - directed self-checking bench for l2_cache against a fixed-latency memory model
module tb_l2_cache;

  typedef logic [15:0][7:0] blk_t;

  logic        clk;
  logic        rst_n;
  logic [10:0] l1_addr;
  blk_t        l1_data_in;
  blk_t        l1_data_out;
  logic        l1_read;
  logic        l1_write;
  logic        l1_ready;
  logic        l1_hit;
  logic [10:0] mem_addr;
  blk_t        mem_data_out;
  blk_t        mem_data_in;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready;

  int n_vec = 0;
  int n_err = 0;

  int          n_mem_rd = 0;
  int          n_mem_wr = 0;
  int          mem_seq  = 0;
  int          rd_seq   = 0;
  int          wr_seq   = 0;
  logic [10:0] last_rd_addr = '0;
  logic [10:0] last_wr_addr = '0;
  blk_t        last_wr_data = '0;

  l2_cache dut (
    .clk(clk), .rst_n(rst_n),
    .l1_addr(l1_addr), .l1_data_in(l1_data_in), .l1_data_out(l1_data_out),
    .l1_read(l1_read), .l1_write(l1_write), .l1_ready(l1_ready), .l1_hit(l1_hit),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic blk_t mem_blk(input int b);
    blk_t r;
    for (int k = 0; k < 16; k++) r[k] = 8'((b + k) & 255);
    return r;
  endfunction

  function automatic blk_t pat_blk(input int base);
    blk_t r;
    for (int k = 0; k < 16; k++) r[k] = 8'((base + k) & 255);
    return r;
  endfunction

  // Memory model: answers each request two cycles after it is seen; a reset drops it.
  initial begin
    logic        is_wr;
    logic [10:0] a;
    logic        aborted;
    mem_ready   = 1'b0;
    mem_data_in = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (mem_read || mem_write)) begin
        is_wr   = mem_write;
        a       = mem_addr;
        aborted = 1'b0;
        mem_seq++;
        if (is_wr) begin
          n_mem_wr++;
          wr_seq       = mem_seq;
          last_wr_addr = a;
          last_wr_data = mem_data_out;
        end else begin
          n_mem_rd++;
          rd_seq       = mem_seq;
          last_rd_addr = a;
        end
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted) begin
          mem_data_in = is_wr ? '0 : mem_blk(int'(a >> 4));
          mem_ready   = 1'b1;
          @(negedge clk);
          mem_ready   = 1'b0;
        end
      end
    end
  end

  task automatic do_req(input logic wr, input logic [10:0] addr, input blk_t wdata,
                        output logic hit, output blk_t rdata, output int lat);
    @(negedge clk);
    l1_addr    = addr;
    l1_data_in = wdata;
    l1_write   = wr;
    l1_read    = !wr;
    @(posedge clk);
    lat   = 0;
    hit   = 1'bx;
    rdata = 'x;
    while (1) begin
      @(negedge clk);
      lat++;
      if (l1_ready) begin
        hit   = l1_hit;
        rdata = l1_data_out;
        break;
      end
      if (lat > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL req_timeout addr=%h: got no l1_ready, want l1_ready within 200 cycles", addr);
        break;
      end
    end
    @(posedge clk);
    #1;
    l1_read  = 1'b0;
    l1_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    l1_addr = '0; l1_data_in = '0; l1_read = 1'b0; l1_write = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if ({l1_ready, l1_hit, mem_read, mem_write} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000", {l1_ready, l1_hit, mem_read, mem_write}); end
    n_vec++; if (mem_addr !== 11'h0) begin
      n_err++; $display("FAIL reset_mem_addr: got %h want 000", mem_addr); end
    n_vec++; if (l1_data_out !== '0 || mem_data_out !== '0) begin
      n_err++; $display("FAIL reset_data: got l1=%h mem=%h want 0", l1_data_out, mem_data_out); end
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    logic hit; blk_t d; int lat;
    do_req(1'b0, 11'h001, '0, hit, d, lat);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL cold_hit: got %b want 0", hit); end
    n_vec++; if (d !== mem_blk(0)) begin n_err++; $display("FAIL cold_data: got %h want %h", d, mem_blk(0)); end
    n_vec++; if (n_mem_rd !== 1 || last_rd_addr !== 11'h000) begin
      n_err++; $display("FAIL cold_mem_rd: got n=%0d addr=%h want n=1 addr=000", n_mem_rd, last_rd_addr); end
    n_vec++; if (n_mem_wr !== 0) begin n_err++; $display("FAIL cold_mem_wr: got %0d want 0", n_mem_wr); end
  endtask

  task automatic test_read_hit();
    logic hit; blk_t d; int lat; int rd0;
    rd0 = n_mem_rd;
    do_req(1'b0, 11'h00F, '0, hit, d, lat);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL hit_latency: got %0d want 2", lat); end
    n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL hit_flag: got %b want 1", hit); end
    n_vec++; if (d !== pat_blk(0)) begin n_err++; $display("FAIL hit_data: got %h want %h", d, pat_blk(0)); end
    n_vec++; if (n_mem_rd !== rd0) begin n_err++; $display("FAIL hit_mem_rd: got %0d want %0d", n_mem_rd, rd0); end
  endtask

  task automatic test_write_alloc();
    logic hit; blk_t d; int lat; int rd0; int wr0;
    rd0 = n_mem_rd; wr0 = n_mem_wr;
    do_req(1'b1, 11'h010, pat_blk(8'hA0), hit, d, lat);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL walloc_hit: got %b want 0", hit); end
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL walloc_latency: got %0d want 3", lat); end
    n_vec++; if (n_mem_rd !== rd0 || n_mem_wr !== wr0) begin
      n_err++; $display("FAIL walloc_traffic: got rd=%0d wr=%0d want rd=%0d wr=%0d", n_mem_rd, n_mem_wr, rd0, wr0); end
    do_req(1'b0, 11'h010, '0, hit, d, lat);
    n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL walloc_rehit: got %b want 1", hit); end
    n_vec++; if (d !== pat_blk(8'hA0)) begin n_err++; $display("FAIL walloc_data: got %h want %h", d, pat_blk(8'hA0)); end
  endtask

  task automatic test_clean_evict();
    logic [10:0] seq_a [6] = '{11'h000, 11'h100, 11'h200, 11'h300, 11'h000, 11'h400};
    logic        seq_h [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic hit; blk_t d; int lat; int wr0;
    wr0 = n_mem_wr;
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, seq_a[i], '0, hit, d, lat);
      n_vec++; if (hit !== seq_h[i]) begin
        n_err++; $display("FAIL evict_seq_hit[%0d] addr=%h: got %b want %b", i, seq_a[i], hit, seq_h[i]); end
    end
    n_vec++; if (d !== mem_blk(8'h40) || last_rd_addr !== 11'h400) begin
      n_err++; $display("FAIL evict_fill: got data=%h addr=%h want data=%h addr=400", d, last_rd_addr, mem_blk(8'h40)); end
    n_vec++; if (n_mem_wr !== wr0) begin n_err++; $display("FAIL evict_no_wb: got %0d want %0d", n_mem_wr, wr0); end
    do_req(1'b0, 11'h000, '0, hit, d, lat);
    n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL evict_keep_000: got %b want 1", hit); end
    do_req(1'b0, 11'h100, '0, hit, d, lat);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL evict_gone_100: got %b want 0", hit); end
  endtask

  task automatic test_dirty_evict();
    logic [10:0] seq_a [4] = '{11'h110, 11'h210, 11'h310, 11'h410};
    logic hit; blk_t d; int lat; int wr0;
    wr0 = n_mem_wr;
    for (int i = 0; i < 4; i++) do_req(1'b0, seq_a[i], '0, hit, d, lat);
    n_vec++; if (n_mem_wr !== wr0 + 1) begin n_err++; $display("FAIL dirty_wb_count: got %0d want %0d", n_mem_wr, wr0 + 1); end
    n_vec++; if (last_wr_addr !== 11'h010) begin n_err++; $display("FAIL dirty_wb_addr: got %h want 010", last_wr_addr); end
    n_vec++; if (last_wr_data !== pat_blk(8'hA0)) begin
      n_err++; $display("FAIL dirty_wb_data: got %h want %h", last_wr_data, pat_blk(8'hA0)); end
    n_vec++; if (!(wr_seq < rd_seq) || last_rd_addr !== 11'h410) begin
      n_err++; $display("FAIL dirty_order: got wr_seq=%0d rd_seq=%0d rd_addr=%h want wr before rd of 410", wr_seq, rd_seq, last_rd_addr); end
    n_vec++; if (hit !== 1'b0 || d !== mem_blk(8'h41)) begin
      n_err++; $display("FAIL dirty_fill: got hit=%b data=%h want hit=0 data=%h", hit, d, mem_blk(8'h41)); end
  endtask

  task automatic test_reset_mid_fill();
    logic hit; blk_t d; int lat; int t;
    @(negedge clk);
    l1_addr = 11'h500; l1_data_in = '0; l1_read = 1'b1;
    t = 0;
    do begin @(posedge clk); #2; t++; end while (!mem_read && t < 50);
    n_vec++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL midfill_req: got mem_read=%b want 1", mem_read); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({l1_ready, l1_hit, mem_read, mem_write} !== 4'b0 || mem_addr !== 11'h0 ||
                 l1_data_out !== '0 || mem_data_out !== '0) begin
      n_err++; $display("FAIL midfill_outputs: got ctrl=%b addr=%h want all 0", {l1_ready, l1_hit, mem_read, mem_write}, mem_addr); end
    l1_read = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    do_req(1'b0, 11'h500, '0, hit, d, lat);
    n_vec++; if (hit !== 1'b0 || d !== mem_blk(8'h50)) begin
      n_err++; $display("FAIL midfill_reread: got hit=%b data=%h want hit=0 data=%h", hit, d, mem_blk(8'h50)); end
    do_req(1'b0, 11'h000, '0, hit, d, lat);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL midfill_invalidated: got %b want 0", hit); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_read_hit();
    test_write_alloc();
    test_clean_evict();
    test_dirty_evict();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
